led_waveform_gen: RTL and testbench
===================================

# led_waveform_gen

Parametrised multi-channel LED waveform generator, successor to the single-output fixed-waveform blinkers in the lab designs. A shared prescaler derives a slow tick from the board clock (50 MHz, 20 ns period). Each tick drives one of three runtime-selectable waveforms onto CH LED outputs: binary blink, rotating pattern chaser, or PWM dimming. The block sits directly between the board clock/reset and the LED pins. Mode and data are latched through a single load strobe.

## Interface
- PRESCALE, 25_000_000: iCLK cycles per tick; legal range ≥ 2.
- CH, 4: number of LED channels; legal range 1..8.
- PAT_W, 8: pattern length in bits; legal range 2..32.
- iCLK  in  1  board clock; all logic on its rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iLOAD  in  1  one-cycle strobe; latches iMODE, iPATTERN, iDUTY.
- iMODE  in  2  mode code: 00 off, 01 blink, 10 pattern, 11 PWM.
- iPATTERN  in  PAT_W  pattern for mode 10.
- iDUTY  in  4  PWM duty in sixteenths for mode 11.
- oLED  out  CH  LED drive, registered.
- oTICK  out  1  one-cycle pulse per prescaler tick, registered.

## Operation
- **Latched configuration registers:** mode_r (2 bits), pat_r (PAT_W bits), duty_r (4 bits). They are written only when iLOAD=1 at a clock edge. Inputs are ignored at all other times.
- **Prescaler:**
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - When cnt==PRESCALE-1, tick_r is set to 1 for exactly one cycle. oTICK = tick_r.
- **Blink state:** bcnt (CH bits) increments on every tick and wraps from 2^CH-1 to 0.
- **Pattern state:** idx (0..PAT_W-1) increments on every tick and wraps from PAT_W-1 to 0.
- **PWM state:** pwm (4 bits) increments every iCLK cycle regardless of tick, giving a 16-cycle period.
- **Output function per mode, for channel k:**
  - 00: oLED = 0.
  - 01: oLED[k] = bcnt[k]. Channel 0 toggles every tick; channel k toggles every 2^k ticks.
  - 10: oLED[k] = pat_r[(idx+k) mod PAT_W]. The pattern rotates across the channels, LSB first.
  - 11: oLED[k] = (pwm < duty_r) for all k. Duty 0 is always off; duty 15 is on for 15 of 16 cycles.
- **iLOAD effects:** besides latching, iLOAD clears cnt, bcnt and idx. The new waveform therefore starts in phase from index 0. pwm is not cleared.
- **iRST:** clears every register: cnt, tick_r, bcnt, idx, pwm, mode_r, pat_r, duty_r, oLED. iRST overrides iLOAD in the same cycle.

## Timing
- **Reset values:** oLED=0, oTICK=0, mode 00.
- **Output registration:** oLED is registered from the state registers. It reflects a state change one cycle after that change (two edges after the causing tick or load).
- **Tick timing:**
  - Take the edge where iRST or iLOAD is last sampled high as edge 0.
  - oTICK is high between edges PRESCALE and PRESCALE+1.
  - After that, oTICK pulses every PRESCALE cycles.
- **Blink/pattern update:** bcnt and idx update on the same edge that sets tick_r. oLED follows on the next edge.
- **Tick coinciding with iLOAD:** iLOAD wins. The counters are cleared and that tick is not emitted.
- **Reset mid-operation:** iRST asserted in any cycle gives all outputs 0 after the next edge. It has no effect on tick spacing other than restarting the count.
- **Wrap behaviour:** bcnt and idx wrap silently, with no glitch or skipped state.

## Test plan
- **Reset and idle:** apply iRST=1 for 3 cycles, then release with PRESCALE=4, CH=4. Expect oLED=0000 and oTICK pulses at cycles 4, 8, 12 after release.
- **Blink:** load iMODE=01. Across 16 ticks, expect oLED to step 0001, 0010, 0011 … 1111, 0000. Bit 0 toggles every tick and bit 3 every 8 ticks.
- **Pattern:** load iMODE=10, iPATTERN=8'b0000_0001 with PAT_W=8.
  - Expect oLED=0001 initially, then 0000 ×4, then 1000, 0100, 0010, 0001 on successive ticks.
  - Expect a wrap at the 8th tick.
- **PWM:** load iMODE=11, then iDUTY=0, 4, 15. Expect 0, 4 and 15 high cycles per 16-cycle window on every channel.
- **Collisions:** pulse iLOAD on the cycle where cnt==PRESCALE-1. Expect no oTICK that cycle and the next oTICK PRESCALE cycles later. Then assert iRST together with iLOAD and expect mode to stay 00 and oLED=0.

Source files
------------

// File: rtl/led_waveform_gen.sv
// Multi-channel LED waveform generator: a shared prescaler tick drives blink,
// rotating-pattern or PWM waveforms onto CH registered LED outputs.
module led_waveform_gen #(
  parameter int unsigned PRESCALE = 25_000_000,
  parameter int unsigned CH       = 4,
  parameter int unsigned PAT_W    = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iLOAD,
  input  logic [1:0]       iMODE,
  input  logic [PAT_W-1:0] iPATTERN,
  input  logic [3:0]       iDUTY,
  output logic [CH-1:0]    oLED,
  output logic             oTICK
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = $clog2(PAT_W);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_PATTERN = 2'b10,
    MODE_PWM     = 2'b11
  } mode_t;

  mode_t            modeR;
  logic [PAT_W-1:0] patR;
  logic [3:0]       dutyR;
  logic [CNT_W-1:0] cnt;
  logic             tickR;
  logic [CH-1:0]    bcnt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       pwm;
  logic             tickHit;
  logic [CH-1:0]    ledNext;

  assign tickHit = (cnt == CNT_W'(PRESCALE - 1));
  assign oTICK   = tickR;

  function automatic logic [IDX_W-1:0] rotIdx(input logic [IDX_W-1:0] base,
                                              input int unsigned     off);
    int unsigned sum;
    sum = int'(base) + off;
    return IDX_W'(sum % PAT_W);
  endfunction

  always_comb begin
    ledNext = '0;
    case (modeR)
      MODE_BLINK:   ledNext = bcnt;
      MODE_PATTERN: begin
        for (int unsigned k = 0; k < CH; k++) begin
          ledNext[k] = patR[rotIdx(idx, k)];
        end
      end
      MODE_PWM:     ledNext = (pwm < dutyR) ? '1 : '0;
      default:      ledNext = '0;
    endcase
  end

  // A load takes priority over a coincident tick: counters restart and the tick is dropped.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      modeR <= MODE_OFF;
      patR  <= '0;
      dutyR <= '0;
      cnt   <= '0;
      tickR <= 1'b0;
      bcnt  <= '0;
      idx   <= '0;
      pwm   <= '0;
      oLED  <= '0;
    end else begin
      pwm  <= pwm + 4'd1;
      oLED <= ledNext;
      if (iLOAD) begin
        modeR <= mode_t'(iMODE);
        patR  <= iPATTERN;
        dutyR <= iDUTY;
        cnt   <= '0;
        bcnt  <= '0;
        idx   <= '0;
        tickR <= 1'b0;
      end else begin
        tickR <= tickHit;
        if (tickHit) begin
          cnt  <= '0;
          bcnt <= bcnt + CH'(1);
          idx  <= (idx == IDX_W'(PAT_W - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_waveform_gen.sv
// Scoreboard bench for led_waveform_gen: an arithmetic reference model queues the
// expected outputs per edge; a negedge monitor pops and compares them.
module tb_led_waveform_gen;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CH       = 4;
  localparam int unsigned PAT_W    = 8;

  logic             clk;
  logic             iRST;
  logic             iLOAD;
  logic [1:0]       iMODE;
  logic [PAT_W-1:0] iPATTERN;
  logic [3:0]       iDUTY;
  logic [CH-1:0]    oLED;
  logic             oTICK;

  led_waveform_gen #(
    .PRESCALE(PRESCALE),
    .CH      (CH),
    .PAT_W   (PAT_W)
  ) dut (
    .iCLK    (clk),
    .iRST    (iRST),
    .iLOAD   (iLOAD),
    .iMODE   (iMODE),
    .iPATTERN(iPATTERN),
    .iDUTY   (iDUTY),
    .oLED    (oLED),
    .oTICK   (oTICK)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          tick;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state expressed as elapsed edges rather than counters.
  bit               started = 0;
  logic [1:0]       mM;
  logic [PAT_W-1:0] pM;
  logic [3:0]       dM;
  int unsigned      sClr;
  int unsigned      age;

  function automatic logic [CH-1:0] ledOf(input logic [1:0] m, input logic [PAT_W-1:0] p,
                                          input logic [3:0] d, input int unsigned s,
                                          input int unsigned a);
    int unsigned   n;
    logic [CH-1:0] r;
    n = s / PRESCALE;
    r = '0;
    case (m)
      2'b01: r = CH'(n % (1 << CH));
      2'b10: for (int k = 0; k < CH; k++) r[k] = p[(n + k) % PAT_W];
      2'b11: r = ((a % 16) < d) ? '1 : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (iRST) begin
      e.led  = '0;
      e.tick = 1'b0;
      mM = 2'b00; pM = '0; dM = '0;
      sClr = 0; age = 0;
      started = 1;
      q.push_back(e);
    end else if (started) begin
      e.led = ledOf(mM, pM, dM, sClr, age);
      if (iLOAD) begin
        mM = iMODE; pM = iPATTERN; dM = iDUTY;
        sClr = 0;
      end else begin
        sClr++;
      end
      age++;
      e.tick = (sClr != 0) && (sClr % PRESCALE == 0);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (oLED !== e.led) begin
        failures++;
        $display("FAIL oLED t=%0t got=%b exp=%b", $time, oLED, e.led);
      end
      checks++;
      if (oTICK !== e.tick) begin
        failures++;
        $display("FAIL oTICK t=%0t got=%b exp=%b", $time, oTICK, e.tick);
      end
    end
  end

  task automatic cyc(input logic r, input logic l, input logic [1:0] m,
                     input logic [PAT_W-1:0] p, input logic [3:0] d);
    iRST = r; iLOAD = l; iMODE = m; iPATTERN = p; iDUTY = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'($urandom), PAT_W'($urandom), 4'($urandom));
  endtask

  task automatic load(input logic [1:0] m, input logic [PAT_W-1:0] p, input logic [3:0] d);
    cyc(1'b0, 1'b1, m, p, d);
  endtask

  initial begin
    iRST = 1'b1; iLOAD = 1'b0; iMODE = '0; iPATTERN = '0; iDUTY = '0;
    repeat (3) cyc(1'b1, 1'b0, 2'b00, '0, 4'd0);
    idle(14);

    load(2'b01, '0, 4'd0);
    idle(16 * PRESCALE + 4);

    load(2'b10, 8'b0000_0001, 4'd0);
    idle(9 * PRESCALE + 2);

    load(2'b11, '0, 4'd0);
    idle(40);
    load(2'b11, '0, 4'd4);
    idle(40);
    load(2'b11, '0, 4'd15);
    idle(40);

    // Second load lands on the cycle where the prescaler would tick.
    load(2'b01, '0, 4'd0);
    idle(PRESCALE - 1);
    load(2'b10, 8'b1010_0110, 4'd0);
    idle(3 * PRESCALE + 2);

    cyc(1'b1, 1'b1, 2'b11, 8'hFF, 4'd15);
    idle(12);

    for (int i = 0; i < 400; i++) begin
      logic r;
      logic l;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 9) == 0);
      cyc(r, l, 2'($urandom), PAT_W'($urandom), 4'($urandom));
    end
    idle(4);

    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
